// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add sequencer: chunk width and FSM state type.
package mp_add_pkg;

  localparam int unsigned CHUNK_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/csel_add16.sv
// Combinational 16-bit carry-select adder slice: ripple low byte, high byte precomputed
// for both carry-in values and picked by the low-byte carry.
module csel_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [8:0] lo_sum;
  logic [8:0] hi_sum0;
  logic [8:0] hi_sum1;

  assign lo_sum  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, ci};
  assign hi_sum0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi_sum1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign s[7:0]  = lo_sum[7:0];
  assign s[15:8] = lo_sum[8] ? hi_sum1[7:0] : hi_sum0[7:0];
  assign co      = lo_sum[8] ? hi_sum1[8]   : hi_sum0[8];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one 16-bit chunk per cycle, LSB first, with a registered carry.
// Define MP_SUB_EN to add the op_sub port (A - B via inverted B and forced carry-in).
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHUNK_W*WORDS-1:0]   inA,
  input  logic [CHUNK_W*WORDS-1:0]   inB,
  input  logic                       ci,
`ifdef MP_SUB_EN
  input  logic                       op_sub,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHUNK_W*WORDS-1:0]   out,
  output logic                       co
);

  localparam int unsigned W  = CHUNK_W * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   out_q, out_d;
  logic           carry_q, carry_d;
  logic           co_q, co_d;
  logic [KW-1:0]  k_q, k_d;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b;
  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_co;
  logic               start_carry;

  assign chunk_a = a_q[k_q*CHUNK_W +: CHUNK_W];

`ifdef MP_SUB_EN
  logic sub_q, sub_d;

  // Subtraction is A + ~B + 1; the +1 enters through the initial carry.
  assign chunk_b     = b_q[k_q*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub_q}};
  assign start_carry = op_sub ? 1'b1 : ci;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  always_comb begin
    sub_d = sub_q;
    if (state_q == StIdle && in_valid) begin
      sub_d = op_sub;
    end
  end
`else
  assign chunk_b     = b_q[k_q*CHUNK_W +: CHUNK_W];
  assign start_carry = ci;
`endif

  csel_add16 u_slice (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry_q),
    .s  (chunk_sum),
    .co (chunk_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    co_d    = co_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = inA;
          b_d     = inB;
          carry_d = start_carry;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        out_d[k_q*CHUNK_W +: CHUNK_W] = chunk_sum;
        carry_d = chunk_co;
        if (k_q == KW'(WORDS - 1)) begin
          co_d    = chunk_co;
          state_d = StDone;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      k_q     <= k_d;
    end
  end

  // Handshake outputs come straight from state, never from in_valid/out_ready.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign co        = co_q;

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add sequencer: accepts a WORDS×16-bit operand pair over a valid/ready handshake and computes the sum one 16-bit chunk per cycle, least-significant first. A registered carry chains between chunks, and the result is returned over a second valid/ready handshake. It reuses the team's 16-bit carry-select slice as its datapath, which gives wide arithmetic without widening the carry chain, and it sits between an operand producer and a result consumer.

## Interface
- WORDS, 4, number of 16-bit chunks per operand (≥1)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair and ci presented
- in_ready  out  1  sequencer can accept; high only in IDLE
- inA  in  16*WORDS  operand A
- inB  in  16*WORDS  operand B
- ci  in  1  carry into chunk 0
- op_sub  in  1  subtract select; present only with MP_SUB_EN
- out_valid  out  1  result held on out/co
- out_ready  in  1  consumer accepts result
- out  out  16*WORDS  registered sum
- co  out  1  registered carry out of the top chunk

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, capture inA, inB, ci (and op_sub), clear the chunk index k, set the carry register to ci, and go to RUN.
- RUN: each cycle computes chunk k as A[k] + B[k] + carry, writes the 16-bit sum into out[16k+:16], latches carry-out into the carry register, and increments k. After chunk WORDS-1, co takes the final carry and the FSM goes to DONE.
- DONE: out_valid=1; out and co are stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Captured operands are not affected by input changes after acceptance.
- Arithmetic is modulo 2^(16*WORDS); co is the carry out of bit 16*WORDS-1.
- Reset (any state, including mid-RUN): the FSM returns to IDLE; out_valid=0, out=0, co=0, carry=0, k=0. The in-flight operation is discarded and no result is emitted.
- Reset values: in_ready=1, out_valid=0, out=0, co=0.
- WORDS=1 is legal: RUN lasts one cycle.

## Timing
- An input handshake at edge E writes chunk k at edge E+k+1.
- out_valid rises at edge E+WORDS, giving a latency of WORDS cycles from acceptance.
- out_valid stays high until the cycle in which out_ready=1; the FSM leaves DONE on that edge.
- in_ready is 0 in DONE even when out_ready=1 in the same cycle. A new operand is accepted no earlier than the cycle after the output handshake, so peak throughput is one operation per WORDS+2 cycles.
- in_ready and out_valid are decoded directly from state registers; there is no combinational path from in_valid or out_ready.

## Configuration
- MP_SUB_EN defined: the op_sub port exists. With op_sub=1 (captured at acceptance), each B chunk is inverted and the initial carry is forced to 1, ignoring ci. The result is A−B mod 2^(16*WORDS), and co=1 means no borrow. With op_sub=0, the block performs addition as normal.
- MP_SUB_EN undefined: no op_sub port; add only. The datapath is free of the inversion logic.

## Structure
- Package mp_add_pkg: localparam CHUNK_W=16 and typedef enum for the state (IDLE, RUN, DONE).
- Sub-module csel_add16: a combinational 16-bit carry-select slice (a, b, ci → s, co). The low 8 bits are a ripple adder; the high 8 bits are two ripple adders precomputed for carry 0 and carry 1, selected by the low-half carry.
- The sequencer owns all registers: operand, carry, index, result and FSM.

## Test plan
- WORDS=4, A=0x0000_0000_0000_FFFF, B=0x1, ci=0 → out=0x0000_0000_0001_0000, co=0, out_valid at E+4.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0, ci=1 → out=0, co=1, exercising the carry through every chunk.
- Result backpressure: out_ready held low for 3 cycles in DONE → out/co unchanged, in_ready=0, and in_valid pulses are ignored; result consumed on the first out_ready=1.
- Assert rst at E+2 during RUN → next cycle in_ready=1, out_valid=0, out=0, co=0; a following operation returns the correct sum.
- Back-to-back: two operations with in_valid held high → the second is accepted one cycle after the first output handshake, and both results are correct.
- With MP_SUB_EN: A=5, B=7, op_sub=1 → out=0xFFFF_FFFF_FFFF_FFFE, co=0; A=7, B=5 → out=2, co=1.
